uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit block, the transmit counterpart of the oversampling receiver on the same link. It accepts one parallel data word through a ready/start handshake. It serialises the word as start bit, data bits LSB first, an optional parity bit and stop bit(s). Bit timing comes from the shared baud-rate x OVERSAMPLE tick enable, so TX and RX bit periods match.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, tick enables per bit period (power of two, 2..16)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
tick  input  1  oversample enable, one-cycle pulse at baud x OVERSAMPLE
start  input  1  request to send data_in; qualified by ready
data_in  input  DATA_WIDTH  word to transmit; sampled only on accept
tx  output  1  serial line, idle high, registered
ready  output  1  high when in IDLE and able to accept
done  output  1  one-cycle pulse when a frame has fully completed

Behaviour:
- Reset: every operation below happens only on a rising clk edge with rst=1. Reset values: tx=1, ready=1, done=0, state=IDLE, counters=0, shift register=0. Reset mid-frame aborts the frame; tx is 1 from the next edge and no done pulse is produced.
- ready = (state==IDLE), combinational from the state register.
- Accept: start=1 and ready=1 at an edge.
  - Latch data_in into the shift register.
  - Clear tick_cnt (log2(OVERSAMPLE) bits) and bit_cnt.
  - state<=START and tx<=0 on the same edge.
  - start while ready=0 is ignored; data_in changes after accept have no effect.
- Bit timing: each bit is held for exactly OVERSAMPLE tick pulses.
  - tick_cnt increments on each edge where tick=1.
  - When tick=1 and tick_cnt==OVERSAMPLE-1, tick_cnt wraps to 0 and the FSM advances.
  - Cycles with tick=0 hold all state.
- FSM:
  - IDLE: tx=1; go to START on accept.
  - START: tx=0; at bit end go to DATA, tx<=shift[0].
  - DATA: tx=shift[0]. At bit end, shift right and bit_cnt++. When bit_cnt==DATA_WIDTH-1 at bit end, go to PARITY (feature on) or STOP.
  - PARITY: tx=parity bit; at bit end go to STOP.
  - STOP: tx=1. bit_cnt counts stop bits. At the end of the last stop bit go to IDLE and set done<=1.
- done: high for exactly the first IDLE cycle after a frame. It is cleared on the next edge regardless of start.
- Simultaneous done=1 and start=1: accepted (ready is already 1). The line is high for one clk cycle only between frames.
- Frame length in tick pulses: OVERSAMPLE*(1+DATA_WIDTH+P+STOP_BITS), where P=1 with parity, else 0.
- tx changes only on bit boundaries; it is glitch-free because it is a flop output.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after the MSB, lasting one bit period.
  - Even parity by default: tx = XOR of the latched data bits.
  - Input port parity_odd (1 bit) inverts it for odd parity; it is sampled on accept.
- Undefined: no PARITY state, no parity_odd port, and the frame goes directly from DATA to STOP.

Test Plan:
1. Defaults, tick tied 1, accept data_in=0x55 -> tx pattern 0,1,0,1,0,1,0,1,0,1 with each level lasting 16 cycles; done pulses exactly 160 cycles after the accept edge; ready low throughout.
2. tick every 4th cycle, data_in=0xA3 -> each bit lasts 64 cycles, LSB first (1,1,0,0,0,1,0,1); done at 640 cycles; tx stable between boundaries.
3. start held high continuously with data_in changed mid-frame from 0x0F to 0xF0 -> first frame transmits 0x0F. Second frame is accepted in the done cycle with 0xF0, and its start bit begins one cycle after done.
4. rst asserted for one cycle during data bit 4 -> tx=1, ready=1, done=0 on the next edge; no done pulse afterwards; next accept sends a clean frame.
5. UART_TX_PARITY_EN defined, parity_odd=0: 0x07 -> parity bit 1, 0x55 -> parity bit 0, frame 176 ticks. With parity_odd=1, 0x07 -> parity bit 0.
6. STOP_BITS=2, tick tied 1, data 0xFF -> tx high for 32 cycles after the MSB before done; total 176 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter.
// Sends one frame per accepted word: start bit, data LSB first, optional parity, stop bit(s).
// Each bit is held for OVERSAMPLE pulses of the shared tick enable.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the MSB.
// With UART_TX_PARITY_EN, the parity_odd input selects odd parity. It is sampled on accept.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  tx,
    output logic                  ready,
    output logic                  done
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = 4;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [TCW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_d;
    logic                  done_d;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign ready   = (state_q == IDLE);
    assign bit_end = tick && (tick_cnt_q == TICK_LAST);

    // State, counters, shift register and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            done       <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d is the level for the bit that starts on this edge
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        // OVERSAMPLE is a power of two, so the counter wraps exactly at the bit end
        if (state_q != IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d    = START;
                    shift_d    = data_in;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken from the word now, before shifting consumes it
                    par_d      = (^data_in) ^ parity_odd;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = par_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for uart_tx_serializer.
// Each accepted word is queued; a monitor rebuilds the expected bit list from it and checks tx tick by tick.
// Honours UART_TX_PARITY_EN in the same way as the design.
module tb_uart_tx_serializer;

    localparam int DW = 8;
    localparam int OS = 16;

    typedef struct {
        logic [DW-1:0] d;
        bit            po;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          parity_odd = 1'b0;
    logic          tx, ready, done;

    logic          start2 = 1'b0;
    logic [DW-1:0] data2 = '1;
    logic          tx2, ready2, done2;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   frames_sent = 0;
    int   frames_done = 0;
    bit   mon_active = 1'b0;
    int   tick_mode = 0;

    uart_tx_serializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .start(start),
        .data_in(data_in),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx(tx),
        .ready(ready),
        .done(done)
    );

    uart_tx_serializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .start(start2),
        .data_in(data2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(1'b0),
`endif
        .tx(tx2),
        .ready(ready2),
        .done(done2)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels for one frame, one entry per bit period
    task automatic build_bits(input logic [DW-1:0] d, input bit po, input int nstop, output bit b[$]);
        b.delete();
        b.push_back(1'b0);
        for (int i = 0; i < DW; i++) b.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        b.push_back((^d) ^ po);
`endif
        for (int i = 0; i < nstop; i++) b.push_back(1'b1);
    endtask

    // Tick enable generator: 0 = every cycle, 1 = every 4th cycle, other = random
    initial begin : tick_gen
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0:       tick = 1'b1;
                1:       tick = (phase % 4 == 0);
                default: tick = 1'($urandom_range(0, 1));
            endcase
            phase++;
        end
    end

    // Monitor: pops the scoreboard when a frame starts and checks every cycle
    initial begin : monitor
        exp_t e;
        bit   bits[$];
        int   tcount = 0;
        int   total = 0;
        bit   prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("reset_tx", tx, 1'b1);
                chk("reset_ready", ready, 1'b1);
                chk("reset_done", done, 1'b0);
                mon_active = 1'b0;
            end else if (mon_active) begin
                if (tcount < total) begin
                    chk("tx_bit", tx, bits[tcount / OS]);
                    chk("ready_busy", ready, 1'b0);
                    chk("done_busy", done, 1'b0);
                end else begin
                    chk("done_pulse", done, 1'b1);
                    chk("ready_end", ready, 1'b1);
                    chk("tx_end", tx, 1'b1);
                    mon_active = 1'b0;
                    frames_done++;
                end
            end else if (!ready) begin
                if (sb.size() == 0) begin
                    chk_int("frame_expected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    build_bits(e.d, e.po, 1, bits);
                    total = bits.size() * OS;
                    tcount = 0;
                    mon_active = 1'b1;
                    chk("tx_start", tx, bits[0]);
                    chk("done_start", done, 1'b0);
                end
            end else begin
                chk("idle_tx", tx, 1'b1);
                chk("idle_done", done, 1'b0);
            end
            if (mon_active && tick) tcount++;
            prev_rst = rst;
        end
    end

    task automatic wait_ready_push(input logic [DW-1:0] d, input bit po);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 20000) begin
                chk("accept_timeout", ready, 1'b1);
                return;
            end
        end
        sb.push_back('{d: d, po: po});
        frames_sent++;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit po);
        @(posedge clk);
        #1;
        start = 1'b1;
        data_in = d;
        parity_odd = po;
        wait_ready_push(d, po);
        @(posedge clk);
        #1;
        start = 1'b0;
        data_in = DW'($urandom);
        parity_odd = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ready && !mon_active && sb.size() == 0) && n < 20000);
        if (n >= 20000) chk("idle_timeout", mon_active, 1'b0);
    endtask

    initial begin : watchdog
        #800000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit bits2[$];
        int j;
        int tot2;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Tick every cycle, alternating pattern
        tick_mode = 0;
        send(8'h55, 1'b0);
        wait_idle();

        // Tick every 4th cycle
        tick_mode = 1;
        send(8'hA3, 1'b0);
        wait_idle();

        // start held through two frames; data changes mid-frame
        tick_mode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        data_in = 8'h0F;
        parity_odd = 1'b0;
        wait_ready_push(8'h0F, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        data_in = 8'hF0;
        wait_ready_push(8'hF0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset during data bit 4 aborts the frame
        send(8'h33, 1'b0);
        repeat (85) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        send(8'hC9, 1'b0);
        wait_idle();

        // Parity words
        send(8'h07, 1'b0);
        wait_idle();
        send(8'h55, 1'b0);
        wait_idle();
        send(8'h07, 1'b1);
        wait_idle();

        // Randomized frames, busy-time start pulses, back-to-back accepts
        for (int f = 0; f < 16; f++) begin
            tick_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            send(DW'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat (5) @(posedge clk);
                #1;
                start = 1'b1;
                data_in = DW'($urandom);
                repeat (3) @(posedge clk);
                #1;
                start = 1'b0;
            end
            if ($urandom_range(0, 3) != 0) wait_idle();
        end
        wait_idle();

        // Two stop bits, tick every cycle, all-ones word
        tick_mode = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("dut2_ready", ready2, 1'b1);
        @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        build_bits(data2, 1'b0, 2, bits2);
        tot2 = bits2.size() * OS;
        j = 0;
        while (1) begin
            @(negedge clk);
            if (j == tot2) begin
                chk("dut2_done", done2, 1'b1);
                chk("dut2_tx_end", tx2, 1'b1);
                break;
            end
            chk("dut2_tx", tx2, bits2[j / OS]);
            chk("dut2_done_busy", done2, 1'b0);
            j++;
        end

        chk_int("queue_empty", sb.size(), 0);
        chk_int("frames_done", frames_done, frames_sent - 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
